// File: rtl/period_finder_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | period_finder_scheduler: round-robin front end sharing one period_finder     |
// | engine. Define PF_SCHED_STATS_EN for stat_ok/stat_fail/stat_busy. Rev 1.0     |
// +----------------------------------------------------------------------------+
module period_finder_scheduler #(
  parameter int WIDTH          = 4,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_modulus,
  input  logic [NUM_REQ*WIDTH-1:0] req_base,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_period,
  output logic [WIDTH-1:0]         rsp_mu,
  output logic [1:0]               rsp_status,
  output logic                     pf_start,
  output logic [WIDTH-1:0]         pf_modulus,
  output logic [WIDTH-1:0]         pf_base,
  output logic                     pf_reset_n,
  input  logic                     pf_done,
  input  logic                     pf_stuck,
  input  logic [WIDTH-1:0]         pf_period,
  input  logic [WIDTH-1:0]         pf_mu_counter
`ifdef PF_SCHED_STATS_EN
  ,
  output logic [15:0]              stat_ok,
  output logic [15:0]              stat_fail,
  output logic [15:0]              stat_busy
`endif
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_ISSUE   = 3'd1;
  localparam logic [2:0] c_ST_WAIT    = 3'd2;
  localparam logic [2:0] c_ST_RECOVER = 3'd3;
  localparam logic [2:0] c_ST_RESPOND = 3'd4;

  localparam logic [1:0] c_RSP_OK      = 2'b00;
  localparam logic [1:0] c_RSP_STUCK   = 2'b01;
  localparam logic [1:0] c_RSP_TIMEOUT = 2'b10;
  localparam logic [1:0] c_RSP_REJECT  = 2'b11;

  localparam logic [15:0]     c_TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W:0]   c_NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_LAST_IDX  = ID_W'(NUM_REQ - 1);

  logic [2:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [15:0]      timer_q;
  logic [WIDTH-1:0] mod_q, base_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_period_q, rsp_mu_q;
  logic [1:0]       rsp_status_q;

  logic             grant_vld_w;
  logic [ID_W-1:0]  grant_idx_w;
  logic [ID_W-1:0]  next_ptr_w;
  logic [WIDTH-1:0] sel_mod_w, sel_base_w;
  logic             reject_w;
  logic             timeout_w;

  // Scan requesters starting at the pointer, wrapping at NUM_REQ.
  always_comb begin
    logic [ID_W:0] sum;
    sum         = '0;
    grant_vld_w = 1'b0;
    grant_idx_w = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= c_NUM_REQ_X) begin
        sum = sum - c_NUM_REQ_X;
      end
      if (!grant_vld_w && req_valid[sum[ID_W-1:0]]) begin
        grant_vld_w = 1'b1;
        grant_idx_w = sum[ID_W-1:0];
      end
    end
  end

  assign next_ptr_w = (grant_idx_w == c_LAST_IDX) ? '0 : grant_idx_w + 1'b1;
  assign sel_mod_w  = req_modulus[grant_idx_w*WIDTH +: WIDTH];
  assign sel_base_w = req_base[grant_idx_w*WIDTH +: WIDTH];
  assign reject_w   = (sel_mod_w < WIDTH'(2)) || (sel_base_w == '0);
  assign timeout_w  = (timer_q == c_TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (grant_vld_w) begin
          state_d = reject_w ? c_ST_RESPOND : c_ST_ISSUE;
        end
      end
      c_ST_ISSUE:   state_d = c_ST_WAIT;
      c_ST_WAIT: begin
        if (pf_done || pf_stuck) begin
          state_d = c_ST_RESPOND;
        end else if (timeout_w) begin
          state_d = c_ST_RECOVER;
        end
      end
      c_ST_RECOVER: state_d = c_ST_RESPOND;
      c_ST_RESPOND: begin
        if (rsp_ready) begin
          state_d = c_ST_IDLE;
        end
      end
      default:      state_d = c_ST_IDLE;
    endcase
  end

  // reset_n gates req_ready so no accept leaks out while the block is held in reset.
  always_comb begin
    req_ready  = '0;
    pf_start   = 1'b0;
    rsp_valid  = 1'b0;
    pf_reset_n = reset_n;
    case (state_q)
      c_ST_IDLE: begin
        if (grant_vld_w && reset_n) begin
          req_ready[grant_idx_w] = 1'b1;
        end
      end
      c_ST_ISSUE:   pf_start   = 1'b1;
      c_ST_RECOVER: pf_reset_n = 1'b0;
      c_ST_RESPOND: rsp_valid  = 1'b1;
      default: begin
        req_ready = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      timer_q      <= '0;
      mod_q        <= '0;
      base_q       <= '0;
      rsp_id_q     <= '0;
      rsp_period_q <= '0;
      rsp_mu_q     <= '0;
      rsp_status_q <= c_RSP_OK;
    end else begin
      if (state_q == c_ST_IDLE && grant_vld_w) begin
        ptr_q    <= next_ptr_w;
        mod_q    <= sel_mod_w;
        base_q   <= sel_base_w;
        rsp_id_q <= grant_idx_w;
        if (reject_w) begin
          rsp_period_q <= '0;
          rsp_mu_q     <= '0;
          rsp_status_q <= c_RSP_REJECT;
        end
      end
      if (state_q == c_ST_ISSUE) begin
        timer_q <= '0;
      end
      // Priority inside WAIT: done, then stuck, then timer expiry.
      if (state_q == c_ST_WAIT) begin
        timer_q <= timer_q + 16'd1;
        if (pf_done) begin
          rsp_period_q <= pf_period;
          rsp_mu_q     <= pf_mu_counter;
          rsp_status_q <= c_RSP_OK;
        end else if (pf_stuck) begin
          rsp_period_q <= '0;
          rsp_mu_q     <= pf_mu_counter;
          rsp_status_q <= c_RSP_STUCK;
        end else if (timeout_w) begin
          rsp_period_q <= '0;
          rsp_mu_q     <= '0;
          rsp_status_q <= c_RSP_TIMEOUT;
        end
      end
    end
  end

  assign pf_modulus = mod_q;
  assign pf_base    = base_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_period = rsp_period_q;
  assign rsp_mu     = rsp_mu_q;
  assign rsp_status = rsp_status_q;

`ifdef PF_SCHED_STATS_EN
  logic [15:0] stat_ok_q, stat_fail_q, stat_busy_q;
  logic        rsp_fire_w;

  assign rsp_fire_w = (state_q == c_ST_RESPOND) && rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ok_q   <= '0;
      stat_fail_q <= '0;
      stat_busy_q <= '0;
    end else begin
      if (rsp_fire_w && rsp_status_q == c_RSP_OK && stat_ok_q != 16'hFFFF) begin
        stat_ok_q <= stat_ok_q + 16'd1;
      end
      if (rsp_fire_w && rsp_status_q != c_RSP_OK && stat_fail_q != 16'hFFFF) begin
        stat_fail_q <= stat_fail_q + 16'd1;
      end
      if (state_q != c_ST_IDLE && stat_busy_q != 16'hFFFF) begin
        stat_busy_q <= stat_busy_q + 16'd1;
      end
    end
  end

  assign stat_ok   = stat_ok_q;
  assign stat_fail = stat_fail_q;
  assign stat_busy = stat_busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_period_finder_scheduler.sv
`default_nettype none
// Bench for period_finder_scheduler: per-requester job queues feed the DUT, a
// scoreboard of expected responses is filled at each accept and drained at each response.
module tb_period_finder_scheduler;
  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int TMO     = 64;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] period;
    logic [3:0] mu;
    logic [1:0] status;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_modulus = '0;
  logic [NUM_REQ*WIDTH-1:0] req_base = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b1;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_period, rsp_mu;
  logic [1:0]               rsp_status;
  logic                     pf_start;
  logic [WIDTH-1:0]         pf_modulus, pf_base;
  logic                     pf_reset_n;
  logic                     pf_done = 1'b0;
  logic                     pf_stuck = 1'b0;
  logic [WIDTH-1:0]         pf_period = '0;
  logic [WIDTH-1:0]         pf_mu_counter = '0;

  period_finder_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_modulus(req_modulus), .req_base(req_base),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_period(rsp_period), .rsp_mu(rsp_mu), .rsp_status(rsp_status),
    .pf_start(pf_start), .pf_modulus(pf_modulus), .pf_base(pf_base),
    .pf_reset_n(pf_reset_n), .pf_done(pf_done), .pf_stuck(pf_stuck),
    .pf_period(pf_period), .pf_mu_counter(pf_mu_counter)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] jm[NUM_REQ][$];
  logic [3:0] jb[NUM_REQ][$];
  exp_t       sb[$];
  int         grant_log[$];

  // engine model: 0 done, 1 stuck, 2 silent, 3 done+stuck together
  int         eng_mode = 0;
  int         eng_delay = 2;
  logic [3:0] eng_period = 4'd5;
  logic [3:0] eng_mu = 4'd1;

  int   cyc = 0;
  int   grant_cyc = 0, start_cyc = 0, recov_cyc = 0;
  int   starts = 0, recovs = 0, n_rsp = 0;
  bit   busy = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  logic [11:0] prev_bus = '0;
  int   mon_gi;
  logic [3:0] mon_m, mon_b;
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit jobs_empty();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (jm[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) cyc++;

  // Requester side: present the head job of each queue until it is accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (jm[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_modulus[i*WIDTH +: WIDTH] = jm[i][0];
        req_base[i*WIDTH +: WIDTH] = jb[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk);
    if (reset_n === 1'b1 && pf_start === 1'b1 && eng_mode != 2) begin
      repeat (eng_delay) @(negedge clk);
      pf_done       = (eng_mode == 0 || eng_mode == 3);
      pf_stuck      = (eng_mode == 1 || eng_mode == 3);
      pf_period     = eng_period;
      pf_mu_counter = eng_mu;
      @(negedge clk);
      pf_done  = 1'b0;
      pf_stuck = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (req_ready !== '0) begin
        chk("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("grant_while_busy", 32'(busy), 32'd0);
        mon_gi = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] === 1'b1) mon_gi = i;
        grant_log.push_back(mon_gi);
        grant_cyc = cyc;
        busy = 1'b1;
        if (jm[mon_gi].size() == 0) begin
          chk("grant_without_job", 32'd1, 32'd0);
        end else begin
          mon_m = jm[mon_gi].pop_front();
          mon_b = jb[mon_gi].pop_front();
          mon_e.id = 2'(mon_gi);
          if (mon_m < 4'd2 || mon_b == 4'd0) begin
            mon_e.period = 4'd0; mon_e.mu = 4'd0; mon_e.status = 2'b11;
          end else if (eng_mode == 2) begin
            mon_e.period = 4'd0; mon_e.mu = 4'd0; mon_e.status = 2'b10;
          end else if (eng_mode == 1) begin
            mon_e.period = 4'd0; mon_e.mu = eng_mu; mon_e.status = 2'b01;
          end else begin
            mon_e.period = eng_period; mon_e.mu = eng_mu; mon_e.status = 2'b00;
          end
          sb.push_back(mon_e);
        end
      end
      if (pf_start === 1'b1) begin
        starts++;
        start_cyc = cyc;
        chk("start_after_grant", 32'(cyc - grant_cyc), 32'd1);
      end
      if (pf_reset_n === 1'b0) begin
        recovs++;
        recov_cyc = cyc;
        chk("recover_after_wait", 32'(cyc - start_cyc), 32'(TMO + 1));
      end
      if (prev_valid && !prev_hs) begin
        chk("rsp_hold", 32'(rsp_valid), 32'd1);
        chk("rsp_stable", 32'({rsp_id, rsp_period, rsp_mu, rsp_status}), 32'(prev_bus));
      end
      if (rsp_valid === 1'b1 && !prev_valid && sb.size() > 0) begin
        if (sb[0].status == 2'b11) chk("reject_latency", 32'(cyc - grant_cyc), 32'd1);
        if (sb[0].status == 2'b10) chk("rsp_after_recover", 32'(cyc - recov_cyc), 32'd1);
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        n_rsp++;
        busy = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("rsp_period", 32'(rsp_period), 32'(mon_e.period));
          chk("rsp_mu", 32'(rsp_mu), 32'(mon_e.mu));
          chk("rsp_status", 32'(rsp_status), 32'(mon_e.status));
        end
      end
      prev_valid = (rsp_valid === 1'b1);
      prev_hs    = prev_valid && (rsp_ready === 1'b1);
      prev_bus   = {rsp_id, rsp_period, rsp_mu, rsp_status};
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(jobs_empty() && sb.size() == 0 && !busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic push_job(input int r, input logic [3:0] m, input logic [3:0] b);
    jm[r].push_back(m);
    jb[r].push_back(b);
  endtask

  int n0, r0, k;
  int rr_exp[4] = '{0, 2, 0, 2};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_pf_start", 32'(pf_start), 32'd0);
    chk("rst_pf_operands", 32'({pf_modulus, pf_base}), 32'd0);
    chk("rst_rsp_fields", 32'({rsp_id, rsp_period, rsp_mu, rsp_status}), 32'd0);
    chk("rst_pf_reset_n", 32'(pf_reset_n), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_pf_reset_n", 32'(pf_reset_n), 32'd1);

    // two requesters, two jobs each: pointer walks 0,2,0,2
    grant_log.delete();
    push_job(0, 4'd9, 4'd2);  push_job(0, 4'd10, 4'd3);
    push_job(2, 4'd13, 4'd4); push_job(2, 4'd7, 4'd5);
    wait_idle(300, "rr_done");
    chk("rr_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      for (k = 0; k < 4; k++) chk("rr_order", 32'(grant_log[k]), 32'(rr_exp[k]));
    end

    eng_mode = 0; eng_delay = 10; eng_period = 4'd4; eng_mu = 4'd3;
    n0 = starts; grant_log.delete();
    push_job(1, 4'd15, 4'd2);
    wait_idle(100, "single_done");
    chk("single_grants", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) chk("single_grant_id", 32'(grant_log[0]), 32'd1);
    chk("single_starts", 32'(starts - n0), 32'd1);

    eng_mode = 1; eng_delay = 5; eng_period = 4'd9; eng_mu = 4'd6;
    push_job(0, 4'd13, 4'd5);
    wait_idle(100, "stuck_done");

    eng_mode = 3; eng_delay = 1; eng_period = 4'd7; eng_mu = 4'd2;
    push_job(2, 4'd11, 4'd3);
    wait_idle(100, "done_stuck_done");

    eng_mode = 2; r0 = recovs;
    push_job(3, 4'd9, 4'd4);
    wait_idle(300, "timeout_done");
    chk("timeout_recover_cycles", 32'(recovs - r0), 32'd1);

    eng_mode = 0; eng_delay = 2; eng_period = 4'd5; eng_mu = 4'd1;
    n0 = starts;
    push_job(0, 4'd1, 4'd7); push_job(0, 4'd9, 4'd0);
    wait_idle(100, "reject_done");
    chk("reject_no_start", 32'(starts - n0), 32'd0);

    // backpressure: second requester must wait for the stalled response
    eng_delay = 3; eng_period = 4'd6; eng_mu = 4'd2;
    grant_log.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    push_job(1, 4'd11, 4'd2); push_job(2, 4'd14, 4'd3);
    n0 = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n0 < 50) begin @(negedge clk); n0++; end
    chk("stall_rsp_seen", 32'(n0 < 50), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle(100, "stall_done");
    chk("stall_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) chk("stall_second_id", 32'(grant_log[1]), 32'd2);

    // reset during WAIT drops the job; pointer restarts at 0
    eng_mode = 2; n0 = starts;
    push_job(2, 4'd11, 4'd3);
    r0 = 0;
    @(negedge clk);
    while (starts == n0 && r0 < 20) begin @(negedge clk); r0++; end
    chk("midrst_started", 32'(r0 < 20), 32'd1);
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_pf_start", 32'(pf_start), 32'd0);
    chk("midrst_pf_operands", 32'({pf_modulus, pf_base}), 32'd0);
    chk("midrst_rsp_fields", 32'({rsp_id, rsp_period, rsp_mu, rsp_status}), 32'd0);
    chk("midrst_pf_reset_n", 32'(pf_reset_n), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    sb.delete(); busy = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    eng_mode = 0; eng_delay = 2; eng_period = 4'd5; eng_mu = 4'd4;
    grant_log.delete();
    push_job(1, 4'd12, 4'd5); push_job(3, 4'd10, 4'd7);
    wait_idle(100, "post_reset_done");
    chk("post_reset_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) chk("post_reset_first", 32'(grant_log[0]), 32'd1);

    chk("rsp_count", 32'(n_rsp), 32'd14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
